// File: rtl/read_master.sv
// Avalon-MM read master: fetches a block of 16-bit samples from DDR3 into a small FWFT FIFO
// and streams them out on d_out/v/rdy. Optional continuous looping when LOOP_READ_EN is defined.
module read_master #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ddr_waitrequest,
  output logic [31:0] ddr_addr,
  output logic        ddr_read,
  input  logic [15:0] ddr_readdata,
  input  logic        ddr_readdatavalid,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [2:0]  addr,
  input  logic        read,
  input  logic        write,
  output logic [15:0] d_out,
  output logic        v,
  input  logic        rdy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state_reg;
  logic [31:0]       base_reg, length_reg, step_reg;
  logic [31:0]       run_base_reg, run_len_reg, run_step_reg;
  logic [31:0]       issue_cnt_reg, out_cnt_reg;
  logic [31:0]       ddr_addr_reg;
  logic [31:0]       readdata_reg;
  logic [FIFO_AW:0]  pending_reg, fifo_count_reg;
  logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [15:0]       mem [FIFO_DEPTH];

  logic              loop_active;
  logic              start_cmd, soft_cmd, start_ok;
  logic [FIFO_AW+1:0] inflight;
  logic              credit_ok, accept, push, do_push, pop, fifo_full;
  logic              busy, done;
  logic [31:0]       rd_mux;

`ifdef LOOP_READ_EN
  logic loop_reg, run_loop_reg;
  assign loop_active = run_loop_reg;
`else
  assign loop_active = 1'b0;
`endif

  assign start_cmd = write && (addr == 3'd4);
  assign soft_cmd  = write && (addr == 3'd6);
  // A new run may only begin once every earlier read has come home, so stale data never mixes in.
  assign start_ok  = start_cmd && ((state_reg == IDLE) || (state_reg == DONE)) && (pending_reg == '0);

  assign inflight  = {1'b0, fifo_count_reg} + {1'b0, pending_reg};
  assign credit_ok = inflight < (FIFO_AW+2)'(FIFO_DEPTH);
  assign fifo_full = fifo_count_reg == (FIFO_AW+1)'(FIFO_DEPTH);

  assign ddr_read  = (state_reg == ISSUE) && (issue_cnt_reg != 32'd0) && credit_ok;
  assign ddr_addr  = ddr_addr_reg;
  assign accept    = ddr_read && !ddr_waitrequest;

  assign push      = ddr_readdatavalid && (state_reg != IDLE) && !soft_cmd;
  assign pop       = v && rdy;
  assign do_push   = push && (!fifo_full || pop);

  assign v         = fifo_count_reg != '0;
  assign d_out     = v ? mem[rd_ptr_reg] : 16'h0000;

  assign busy      = (state_reg == ISSUE) || (state_reg == DRAIN);
  assign done      = state_reg == DONE;
  assign readdata  = readdata_reg;

  always_comb begin
    rd_mux = 32'hDEADBEEF;
    case (addr)
      3'd0: rd_mux = base_reg;
      3'd1: rd_mux = length_reg;
      3'd2: rd_mux = step_reg;
`ifdef LOOP_READ_EN
      3'd3: rd_mux = {31'b0, loop_reg};
`endif
      3'd5: rd_mux = {30'b0, busy, done};
      default: rd_mux = 32'hDEADBEEF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_reg     <= 32'd0;
      length_reg   <= 32'd0;
      step_reg     <= 32'd1;
      readdata_reg <= 32'd0;
`ifdef LOOP_READ_EN
      loop_reg     <= 1'b0;
`endif
    end else begin
      if (write) begin
        case (addr)
          3'd0: base_reg   <= writedata;
          3'd1: length_reg <= writedata;
          3'd2: step_reg   <= writedata;
`ifdef LOOP_READ_EN
          3'd3: loop_reg   <= writedata[0];
`endif
          default: ;
        endcase
      end
      if (read) readdata_reg <= rd_mux;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      ddr_addr_reg  <= 32'd0;
      issue_cnt_reg <= 32'd0;
      out_cnt_reg   <= 32'd0;
      run_base_reg  <= 32'd0;
      run_len_reg   <= 32'd0;
      run_step_reg  <= 32'd1;
`ifdef LOOP_READ_EN
      run_loop_reg  <= 1'b0;
`endif
    end else if (soft_cmd) begin
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start_ok) begin
            ddr_addr_reg  <= base_reg;
            issue_cnt_reg <= length_reg;
            out_cnt_reg   <= length_reg;
            run_base_reg  <= base_reg;
            run_len_reg   <= length_reg;
            run_step_reg  <= step_reg;
`ifdef LOOP_READ_EN
            run_loop_reg  <= loop_reg;
`endif
            state_reg     <= (length_reg == 32'd0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (pop && (out_cnt_reg != 32'd0)) out_cnt_reg <= out_cnt_reg - 32'd1;
          if (accept) begin
            if (issue_cnt_reg == 32'd1) begin
              if (loop_active) begin
                ddr_addr_reg  <= run_base_reg;
                issue_cnt_reg <= run_len_reg;
              end else begin
                ddr_addr_reg  <= ddr_addr_reg + run_step_reg;
                issue_cnt_reg <= 32'd0;
                state_reg     <= DRAIN;
              end
            end else begin
              ddr_addr_reg  <= ddr_addr_reg + run_step_reg;
              issue_cnt_reg <= issue_cnt_reg - 32'd1;
            end
          end
        end
        DRAIN: begin
          if (pop && (out_cnt_reg != 32'd0)) out_cnt_reg <= out_cnt_reg - 32'd1;
          if (out_cnt_reg == 32'd0) state_reg <= DONE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Outstanding-read counter survives soft reset so late returns stay accounted for.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg <= '0;
    end else begin
      case ({accept, ddr_readdatavalid})
        2'b10:   pending_reg <= pending_reg + 1'b1;
        2'b01:   if (pending_reg != '0) pending_reg <= pending_reg - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else if (soft_cmd) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + 1'b1;
        2'b01:   fifo_count_reg <= fifo_count_reg - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= ddr_readdata;
  end

endmodule

// File: tb/tb_read_master.sv
// Directed bench for read_master: a DDR responder with one-cycle read latency returns
// sample = addr[15:0] ^ 16'h5A00; each scenario task checks its own expectations.
`timescale 1ns/1ps
module tb_read_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ddr_waitrequest = 1'b0;
  logic [31:0] ddr_addr;
  logic        ddr_read;
  logic [15:0] ddr_readdata;
  logic        ddr_readdatavalid;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [2:0]  addr = 3'd0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [15:0] d_out;
  logic        v;
  logic        rdy = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic        hold = 1'b0;
  logic [31:0] ddr_q[$];
  logic [31:0] ret_addr;
  logic [31:0] addr_log[$];
  logic [15:0] out_log[$];
  int          acc_total = 0;
  int          pop_total = 0;
  int          max_inflight = 0;

  always #5 clk = ~clk;

  read_master #(.FIFO_DEPTH(16), .FIFO_AW(4)) dut (
    .clk(clk), .rst(rst),
    .ddr_waitrequest(ddr_waitrequest), .ddr_addr(ddr_addr), .ddr_read(ddr_read),
    .ddr_readdata(ddr_readdata), .ddr_readdatavalid(ddr_readdatavalid),
    .writedata(writedata), .readdata(readdata), .addr(addr), .read(read), .write(write),
    .d_out(d_out), .v(v), .rdy(rdy)
  );

  // DDR responder: in-order returns, one cycle after acceptance unless held
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ddr_readdatavalid <= 1'b0;
      ddr_readdata      <= 16'h0000;
      ddr_q.delete();
    end else begin
      if (ddr_read && !ddr_waitrequest) ddr_q.push_back(ddr_addr);
      if (!hold && ddr_q.size() > 0) begin
        ret_addr = ddr_q.pop_front();
        ddr_readdatavalid <= 1'b1;
        ddr_readdata      <= ret_addr[15:0] ^ 16'h5A00;
      end else begin
        ddr_readdatavalid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (ddr_read && !ddr_waitrequest) begin
        addr_log.push_back(ddr_addr);
        acc_total++;
      end
      if (v && rdy) begin
        out_log.push_back(d_out);
        pop_total++;
      end
      if (acc_total - pop_total > max_inflight) max_inflight = acc_total - pop_total;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    addr = a; writedata = d; write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
    addr = a; read = 1'b1;
    tick();
    read = 1'b0;
    d = readdata;
  endtask

  task automatic clear_logs();
    addr_log.delete();
    out_log.delete();
    acc_total = 0;
    pop_total = 0;
    max_inflight = 0;
  endtask

  task automatic wait_done(output bit ok);
    logic [31:0] st;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      csr_read(3'd5, st);
      if (st[0]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    n_cmp++; if (v !== 1'b0 || ddr_read !== 1'b0 || d_out !== 16'h0 || ddr_addr !== 32'h0 || readdata !== 32'h0) begin
      n_bad++; $display("FAIL reset_outputs: v=%b rd=%b d=%h a=%h rdata=%h required all 0", v, ddr_read, d_out, ddr_addr, readdata);
    end
    csr_read(3'd0, r);
    n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL reset_base: got %h required 00000000", r); end
    csr_read(3'd1, r);
    n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL reset_length: got %h required 00000000", r); end
    csr_read(3'd2, r);
    n_cmp++; if (r !== 32'h1) begin n_bad++; $display("FAIL reset_step: got %h required 00000001", r); end
    csr_read(3'd5, r);
    n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL reset_status: got %h required 00000000", r); end
    csr_read(3'd7, r);
    n_cmp++; if (r !== 32'hDEADBEEF) begin n_bad++; $display("FAIL unmapped_7: got %h required deadbeef", r); end
    csr_read(3'd4, r);
    n_cmp++; if (r !== 32'hDEADBEEF) begin n_bad++; $display("FAIL writeonly_4: got %h required deadbeef", r); end
`ifndef LOOP_READ_EN
    csr_write(3'd3, 32'h1);
    csr_read(3'd3, r);
    n_cmp++; if (r !== 32'hDEADBEEF) begin n_bad++; $display("FAIL loop_absent: got %h required deadbeef", r); end
`endif
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [15:0] exp_out [4] = '{16'h5B00, 16'h5B01, 16'h5B02, 16'h5B03};
    logic [31:0] exp_adr [4] = '{32'h100, 32'h101, 32'h102, 32'h103};
    logic [31:0] r;
    bit ok;
    csr_write(3'd0, 32'h100);
    csr_write(3'd1, 32'd4);
    csr_write(3'd2, 32'd1);
    rdy = 1'b1;
    clear_logs();
    csr_write(3'd4, 32'h1);
    n_cmp++; if (v !== 1'b0 || ddr_read !== 1'b1 || ddr_addr !== 32'h100) begin
      n_bad++; $display("FAIL basic_first_req: v=%b rd=%b a=%h required v=0 rd=1 a=00000100", v, ddr_read, ddr_addr);
    end
    tick();
    n_cmp++; if (v !== 1'b0) begin n_bad++; $display("FAIL basic_lat_early: v=%b required 0", v); end
    tick();
    n_cmp++; if (v !== 1'b1 || d_out !== 16'h5B00) begin
      n_bad++; $display("FAIL basic_lat_first: v=%b d=%h required v=1 d=5b00", v, d_out);
    end
    wait_done(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_done_timeout: done=0 required 1"); end
    n_cmp++; if (addr_log.size() != 4) begin n_bad++; $display("FAIL basic_req_count: got %0d required 4", addr_log.size()); end
    n_cmp++; if (out_log.size() != 4) begin n_bad++; $display("FAIL basic_out_count: got %0d required 4", out_log.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (addr_log[i] !== exp_adr[i]) begin n_bad++; $display("FAIL basic_addr[%0d]: got %h required %h", i, addr_log[i], exp_adr[i]); end
      n_cmp++; if (out_log[i] !== exp_out[i]) begin n_bad++; $display("FAIL basic_data[%0d]: got %h required %h", i, out_log[i], exp_out[i]); end
    end
    csr_read(3'd5, r);
    n_cmp++; if (r !== 32'h1) begin n_bad++; $display("FAIL basic_status: got %h required 00000001", r); end
    $display("test_basic done");
  endtask

  task automatic test_waitrequest();
    logic [15:0] exp_out [4] = '{16'h5B00, 16'h5B01, 16'h5B02, 16'h5B03};
    logic [31:0] exp_adr [4] = '{32'h100, 32'h101, 32'h102, 32'h103};
    bit ok;
    rdy = 1'b1;
    clear_logs();
    csr_write(3'd4, 32'h1);
    tick();
    ddr_waitrequest = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (ddr_read !== 1'b1 || ddr_addr !== 32'h101) begin
        n_bad++; $display("FAIL wait_hold[%0d]: rd=%b a=%h required rd=1 a=00000101", k, ddr_read, ddr_addr);
      end
      tick();
    end
    ddr_waitrequest = 1'b0;
    wait_done(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL wait_done_timeout: done=0 required 1"); end
    n_cmp++; if (addr_log.size() != 4) begin n_bad++; $display("FAIL wait_req_count: got %0d required 4", addr_log.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (addr_log[i] !== exp_adr[i]) begin n_bad++; $display("FAIL wait_addr[%0d]: got %h required %h", i, addr_log[i], exp_adr[i]); end
      n_cmp++; if (out_log[i] !== exp_out[i]) begin n_bad++; $display("FAIL wait_data[%0d]: got %h required %h", i, out_log[i], exp_out[i]); end
    end
    $display("test_waitrequest done");
  endtask

  task automatic test_backpressure();
    logic [31:0] r;
    bit ok;
    csr_write(3'd0, 32'h200);
    csr_write(3'd1, 32'd40);
    rdy = 1'b0;
    clear_logs();
    csr_write(3'd4, 32'h1);
    repeat (100) tick();
    n_cmp++; if (addr_log.size() != 16) begin n_bad++; $display("FAIL bp_outstanding: got %0d required 16", addr_log.size()); end
    n_cmp++; if (max_inflight > 16) begin n_bad++; $display("FAIL bp_max_inflight: got %0d required <=16", max_inflight); end
    n_cmp++; if (v !== 1'b1 || d_out !== 16'h5800) begin n_bad++; $display("FAIL bp_head: v=%b d=%h required v=1 d=5800", v, d_out); end
    csr_read(3'd5, r);
    n_cmp++; if (r !== 32'h2) begin n_bad++; $display("FAIL bp_busy: got %h required 00000002", r); end
    rdy = 1'b1;
    wait_done(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_done_timeout: done=0 required 1"); end
    n_cmp++; if (out_log.size() != 40) begin n_bad++; $display("FAIL bp_out_count: got %0d required 40", out_log.size()); end
    for (int i = 0; i < 40; i++) begin
      n_cmp++; if (out_log[i] !== 16'h5800 + 16'(i)) begin
        n_bad++; $display("FAIL bp_data[%0d]: got %h required %h", i, out_log[i], 16'h5800 + 16'(i));
      end
    end
    $display("test_backpressure done");
  endtask

  task automatic test_zero_and_busy_start();
    logic [31:0] r;
    bit ok;
    csr_write(3'd1, 32'd0);
    clear_logs();
    csr_write(3'd4, 32'h1);
    n_cmp++; if (ddr_read !== 1'b0) begin n_bad++; $display("FAIL zero_no_read: rd=%b required 0", ddr_read); end
    csr_read(3'd5, r);
    n_cmp++; if (r !== 32'h1) begin n_bad++; $display("FAIL zero_done: got %h required 00000001", r); end
    n_cmp++; if (addr_log.size() != 0) begin n_bad++; $display("FAIL zero_reqs: got %0d required 0", addr_log.size()); end
    csr_write(3'd0, 32'h300);
    csr_write(3'd1, 32'd8);
    rdy = 1'b1;
    clear_logs();
    csr_write(3'd4, 32'h1);
    csr_read(3'd5, r);
    n_cmp++; if (r !== 32'h2) begin n_bad++; $display("FAIL busy_status: got %h required 00000002", r); end
    csr_write(3'd0, 32'h900);
    csr_write(3'd4, 32'h1);
    wait_done(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL busy_done_timeout: done=0 required 1"); end
    n_cmp++; if (addr_log.size() != 8 || addr_log[7] !== 32'h307) begin
      n_bad++; $display("FAIL busy_restart_ignored: count=%0d last=%h required 8 / 00000307", addr_log.size(), addr_log[7]);
    end
    n_cmp++; if (out_log.size() != 8 || out_log[7] !== 16'h5907) begin
      n_bad++; $display("FAIL busy_last_data: count=%0d last=%h required 8 / 5907", out_log.size(), out_log[7]);
    end
    $display("test_zero_and_busy_start done");
  endtask

  task automatic test_soft_reset();
    logic [31:0] r;
    bit ok;
    int guard;
    csr_write(3'd0, 32'h400);
    csr_write(3'd1, 32'd20);
    rdy = 1'b0;
    hold = 1'b1;
    clear_logs();
    csr_write(3'd4, 32'h1);
    guard = 0;
    while (ddr_q.size() < 5 && guard < 50) begin
      tick();
      guard++;
    end
    ddr_waitrequest = 1'b1;
    n_cmp++; if (ddr_q.size() != 5) begin n_bad++; $display("FAIL sr_pending: got %0d required 5", ddr_q.size()); end
    csr_write(3'd6, 32'h1);
    n_cmp++; if (v !== 1'b0 || ddr_read !== 1'b0) begin n_bad++; $display("FAIL sr_flush: v=%b rd=%b required 0 0", v, ddr_read); end
    csr_write(3'd4, 32'h1);
    tick();
    n_cmp++; if (ddr_read !== 1'b0) begin n_bad++; $display("FAIL sr_start_pending: rd=%b required 0", ddr_read); end
    csr_read(3'd5, r);
    n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL sr_status: got %h required 00000000", r); end
    clear_logs();
    hold = 1'b0;
    ddr_waitrequest = 1'b0;
    rdy = 1'b1;
    repeat (12) tick();
    n_cmp++; if (v !== 1'b0 || out_log.size() != 0) begin
      n_bad++; $display("FAIL sr_drop_late: v=%b popped=%0d required 0 0", v, out_log.size());
    end
    csr_write(3'd0, 32'h500);
    csr_write(3'd1, 32'd3);
    clear_logs();
    csr_write(3'd4, 32'h1);
    wait_done(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL sr_restart_timeout: done=0 required 1"); end
    n_cmp++; if (out_log.size() != 3 || out_log[0] !== 16'h5F00 || out_log[1] !== 16'h5F01 || out_log[2] !== 16'h5F02) begin
      n_bad++; $display("FAIL sr_restart_data: count=%0d %h %h %h required 3 5f00 5f01 5f02",
                        out_log.size(), out_log[0], out_log[1], out_log[2]);
    end
    $display("test_soft_reset done");
  endtask

`ifdef LOOP_READ_EN
  task automatic test_loop();
    logic [31:0] exp_adr [7] = '{32'h10, 32'h12, 32'h14, 32'h10, 32'h12, 32'h14, 32'h10};
    logic [31:0] r;
    int guard;
    csr_write(3'd3, 32'h1);
    csr_read(3'd3, r);
    n_cmp++; if (r !== 32'h1) begin n_bad++; $display("FAIL loop_csr: got %h required 00000001", r); end
    csr_write(3'd0, 32'h10);
    csr_write(3'd1, 32'd3);
    csr_write(3'd2, 32'd2);
    rdy = 1'b1;
    clear_logs();
    csr_write(3'd4, 32'h1);
    guard = 0;
    while (addr_log.size() < 7 && guard < 100) begin
      tick();
      guard++;
    end
    n_cmp++; if (addr_log.size() < 7) begin n_bad++; $display("FAIL loop_timeout: got %0d reqs required >=7", addr_log.size()); end
    for (int i = 0; i < 7; i++) begin
      n_cmp++; if (addr_log[i] !== exp_adr[i]) begin n_bad++; $display("FAIL loop_addr[%0d]: got %h required %h", i, addr_log[i], exp_adr[i]); end
    end
    repeat (20) tick();
    csr_read(3'd5, r);
    n_cmp++; if (r !== 32'h2) begin n_bad++; $display("FAIL loop_not_done: got %h required 00000002", r); end
    csr_write(3'd6, 32'h1);
    repeat (10) tick();
    csr_write(3'd3, 32'h0);
    csr_write(3'd2, 32'h1);
    $display("test_loop done");
  endtask
`endif

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset_early: begin end
    n_cmp++; if (v !== 1'b0 || ddr_read !== 1'b0 || readdata !== 32'h0) begin
      n_bad++; $display("FAIL in_reset: v=%b rd=%b rdata=%h required 0 0 0", v, ddr_read, readdata);
    end
    rst = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_waitrequest();
    test_backpressure();
    test_zero_and_busy_start();
    test_soft_reset();
`ifdef LOOP_READ_EN
    test_loop();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
